serial_to_parallel: RTL and testbench
=====================================

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter: x, default 8, word width in bits (x >= 2).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin assembling a new word.
REQ-005 Port: bit_valid  input  1  serial_in carries a valid bit this cycle.
REQ-006 Port: serial_in  input  1  serial data bit, MSB first.
REQ-007 Port: data_out  output  x  last completed word; feeds downstream parallel_register data_in.
REQ-008 Port: load  output  1  one-cycle pulse, word complete; feeds downstream parallel_register load.
REQ-009 Port: busy  output  1  high while a word is being assembled (SHIFT state).

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-011 In IDLE, start=1 SHALL clear the shift register and bit counter and move to SHIFT next cycle; bit_valid in IDLE SHALL be ignored.
REQ-012 In SHIFT, each cycle with bit_valid=1 SHALL shift in MSB-first (shreg <= {shreg[x-2:0], serial_in}) and increment the counter; bit_valid=0 cycles SHALL hold shreg and counter.
REQ-013 The counter SHALL be $clog2(x)+1 bits wide and never exceed x.
REQ-014 When the x-th valid bit is sampled in SHIFT, the FSM SHALL move to DONE on the next edge.
REQ-015 In DONE, load SHALL be 1 for exactly that one cycle and data_out SHALL present the assembled word from that cycle onward.
REQ-016 Latency: load SHALL rise on the cycle immediately after the edge that samples the x-th valid bit.
REQ-017 From DONE, the FSM SHALL go to SHIFT (with clear) if start=1, otherwise to IDLE.
REQ-018 start asserted during SHIFT SHALL be ignored; the partial word is not restarted.
REQ-019 data_out SHALL hold its value, unchanged, until the next DONE; partial shifting SHALL never be visible on data_out.
REQ-020 busy SHALL be 1 in SHIFT only; load SHALL be 1 in DONE only; all outputs SHALL be registered or decoded from state only, with no combinational path from inputs.

Reset
REQ-021 rst=1 at a rising edge SHALL force state=IDLE, shreg=0, counter=0, data_out=0, load=0, busy=0, overriding all other inputs.
REQ-022 Reset mid-word SHALL discard the partial word; no load pulse SHALL follow.

Structure
REQ-023 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL be defined as constants in the shared project package; x remains a module parameter.
REQ-024 The data_out holding register SHALL be one instance of the existing parallel_register (x=x, rst=rst, load=DONE decode, data_in=shreg).
REQ-025 Shift register, counter and FSM SHALL live in serial_to_parallel itself; there are no other sub-modules.

Verification (x=8)
REQ-026 Reset 2 cycles, then start pulse and 8 consecutive valid bits 1,0,1,1,0,1,1,0 -> load pulses once, one cycle after the 8th bit; data_out=8'b10110110; busy drops with load.
REQ-027 Same word with bit_valid=0 gaps inserted after bits 2 and 5 -> identical result; load is delayed by the 2 gap cycles; data_out is unchanged before load.
REQ-028 After a completed word, hold start=0 and toggle serial_in/bit_valid for 20 cycles -> data_out stays 8'b10110110, load stays 0, busy stays 0.
REQ-029 start, then 4 valid bits, then start pulsed again, then 4 more bits 0,1,0,1 with word 1011_0101 -> load after the 8th bit total and data_out=8'b10110101 (restart ignored).
REQ-030 start, then 4 valid bits, then rst for 1 cycle -> busy=0, data_out=0, no load; then a full word 01010101 -> data_out=8'b01010101.
REQ-031 start held high through DONE between two back-to-back words 0xB6 and 0x55 -> two load pulses 9 cycles apart; data_out shows 0xB6, then 0x55.

Source files
------------

// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the serial-to-parallel converter: FSM state encodings
// and the bit-counter width rule.
package serial_to_parallel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must be able to hold the value x itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/parallel_register.sv
// Word holding register with a pass-through on load, so a word being loaded
// is already visible on data_out during the load cycle.
module parallel_register #(
    parameter int x = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [x-1:0] data_in,
    output logic [x-1:0] data_out
);

    logic [x-1:0] held;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
        end else if (load) begin
            held <= data_in;
        end
    end

    // load is a state decode upstream, so this mux adds no input-to-output path.
    assign data_out = load ? data_in : held;

endmodule

// File: rtl/serial_to_parallel.sv
// Assembles MSB-first serial bits into x-bit words and pulses load for one
// cycle when a word is complete.
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter int x = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         bit_valid,
    input  logic         serial_in,
    output logic [x-1:0] data_out,
    output logic         load,
    output logic         busy
);

    localparam int CW = cnt_width(x);

    state_t        state;
    logic [x-1:0]  shreg;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // start is deliberately ignored here: a partial word is never restarted.
                    if (bit_valid) begin
                        shreg <= {shreg[x-2:0], serial_in};
                        cnt   <= cnt + CW'(1);
                        if (cnt == CW'(x - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        shreg <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign load = (state == DONE);

    parallel_register #(.x(x)) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data_in  (shreg),
        .data_out (data_out)
    );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (x=8): a vector table for the basic
// and gapped words, then hand-written multi-cycle sequences.
module tb_serial_to_parallel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       serial_in = 1'b0;
    logic [7:0] data_out;
    logic       load;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic       r;
        logic       s;
        logic       bv;
        logic       si;
        logic       exp_load;
        logic       exp_busy;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vq[$];

    serial_to_parallel #(.x(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .serial_in (serial_in),
        .data_out  (data_out),
        .load      (load),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, then settle before sampling.
    task automatic apply(input logic r, input logic s, input logic bv, input logic si);
        rst       = r;
        start     = s;
        bit_valid = bv;
        serial_in = si;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic el, input logic eb, input logic [7:0] ed);
        check({nm, ".load"}, load, el);
        check({nm, ".busy"}, busy, eb);
        check({nm, ".data"}, data_out, ed);
    endtask

    task automatic add(input logic r, input logic s, input logic bv, input logic si,
                       input logic el, input logic eb, input logic [7:0] ed);
        vec_t v;
        v.r = r; v.s = s; v.bv = bv; v.si = si;
        v.exp_load = el; v.exp_busy = eb; v.exp_data = ed;
        vq.push_back(v);
    endtask

    // Shift a word MSB first, holding start at s; checks every cycle and
    // expects load only after the final bit.
    task automatic send_word(input string nm, input logic [7:0] w, input logic s,
                             input logic [7:0] prev);
        for (int i = 7; i >= 0; i--) begin
            apply(1'b0, s, 1'b1, w[i]);
            check_out($sformatf("%s.bit%0d", nm, 7 - i), i == 0, i != 0, (i == 0) ? w : prev);
        end
    endtask

    initial begin
        logic [7:0] w1;
        logic [7:0] w2;
        logic [7:0] w3;
        int         load_cycles[$];

        w1 = 8'b1011_0110;
        w2 = 8'b1011_0101;
        w3 = 8'b0101_0101;

        // Reset, then a contiguous word.
        add(1, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 0, 0, 0, 8'h00);
        add(0, 1, 0, 0, 0, 1, 8'h00);
        for (int i = 7; i >= 0; i--) begin
            add(0, 0, 1, w1[i], i == 0, i != 0, (i == 0) ? w1 : 8'h00);
        end
        add(0, 0, 0, 0, 0, 0, w1);
        // Same word with invalid gaps after bits 2 and 5; serial_in toggled on gaps.
        add(0, 1, 0, 0, 0, 1, w1);
        add(0, 0, 1, w1[7], 0, 1, w1);
        add(0, 0, 1, w1[6], 0, 1, w1);
        add(0, 0, 0, 1,     0, 1, w1);
        add(0, 0, 1, w1[5], 0, 1, w1);
        add(0, 0, 1, w1[4], 0, 1, w1);
        add(0, 0, 1, w1[3], 0, 1, w1);
        add(0, 0, 0, 0,     0, 1, w1);
        add(0, 0, 1, w1[2], 0, 1, w1);
        add(0, 0, 1, w1[1], 0, 1, w1);
        add(0, 0, 1, w1[0], 1, 0, w1);
        add(0, 0, 0, 0,     0, 0, w1);

        foreach (vq[i]) begin
            apply(vq[i].r, vq[i].s, vq[i].bv, vq[i].si);
            check_out($sformatf("vec%0d", i), vq[i].exp_load, vq[i].exp_busy, vq[i].exp_data);
        end

        // Idle activity without start must not disturb anything.
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b0, i[0], i[1]);
            check_out($sformatf("idle%0d", i), 1'b0, 1'b0, w1);
        end

        // Start re-pulsed mid-word is ignored.
        apply(0, 1, 0, 0);
        check_out("restart.start", 0, 1, w1);
        for (int i = 7; i >= 4; i--) begin
            apply(0, 0, 1, w2[i]);
            check_out($sformatf("restart.hi%0d", i), 0, 1, w1);
        end
        apply(0, 1, 0, 0);
        check_out("restart.pulse", 0, 1, w1);
        for (int i = 3; i >= 0; i--) begin
            apply(0, 0, 1, w2[i]);
            check_out($sformatf("restart.lo%0d", i), i == 0, i != 0, (i == 0) ? w2 : w1);
        end
        apply(0, 0, 0, 0);
        check_out("restart.after", 0, 0, w2);

        // Reset mid-word discards the partial word.
        apply(0, 1, 0, 0);
        for (int i = 7; i >= 4; i--) begin
            apply(0, 0, 1, w3[i]);
        end
        check_out("midrst.before", 0, 1, w2);
        apply(1, 0, 0, 0);
        check_out("midrst.rst", 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 1);
            check_out($sformatf("midrst.idle%0d", i), 0, 0, 8'h00);
        end
        apply(0, 1, 0, 0);
        send_word("midrst.word", w3, 1'b0, 8'h00);
        apply(0, 0, 0, 0);
        check_out("midrst.after", 0, 0, w3);

        // Back-to-back words with start held high through DONE.
        apply(0, 1, 0, 0);
        check_out("b2b.start", 0, 1, w3);
        for (int i = 7; i >= 0; i--) begin
            apply(0, 1, 1, w1[i]);
            if (load === 1'b1) load_cycles.push_back(cyc);
        end
        check_out("b2b.word1", 1, 0, w1);
        apply(0, 1, 0, 0);
        check_out("b2b.reenter", 0, 1, w1);
        for (int i = 7; i >= 0; i--) begin
            apply(0, 1, 1, w3[i]);
            if (load === 1'b1) load_cycles.push_back(cyc);
            if (i != 0) check($sformatf("b2b.hold%0d", i), data_out, w1);
        end
        check_out("b2b.word2", 1, 0, w3);
        apply(0, 0, 0, 0);
        check_out("b2b.after", 0, 0, w3);
        check("b2b.load_count", load_cycles.size(), 2);
        if (load_cycles.size() == 2) begin
            check("b2b.load_spacing", load_cycles[1] - load_cycles[0], 9);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
